uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: state encodings,
// parity modes and the clocks-per-bit calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_BYTE,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clocks per serial bit, truncated; CLK_FRE is given in MHz.
  function automatic int calc_cycle(input int clk_fre, input int baud_rate);
    return int'((longint'(clk_fre) * 64'd1000000) / longint'(baud_rate));
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity and
// one or two stop bits, fed through a valid/ready byte handshake.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_pin
);

  localparam int CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam logic [15:0] CYCLE_LAST = 16'(CYCLE - 1);
  localparam logic [2:0]  STOP_LAST  = 3'(STOP_BITS - 1);

  if (CYCLE < 2 || CYCLE > 65535) begin : g_bad_cycle
    $error("uart_tx: CLK_FRE/BAUD_RATE gives an unsupported clocks-per-bit count");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  state_t      state;
  logic [15:0] cycle_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  data_latch;
  logic        bit_done;
  logic        parity_bit;

  assign bit_done   = (cycle_cnt == CYCLE_LAST);
  assign parity_bit = (PARITY == PARITY_EVEN) ? ^data_latch : ~^data_latch;

  // tx_pin is always loaded one clock ahead of the level it must show, so each
  // bit boundary is a single register update and the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cycle_cnt     <= '0;
      bit_cnt       <= '0;
      data_latch    <= '0;
      tx_pin        <= 1'b1;
      tx_data_ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cycle_cnt <= '0;
          bit_cnt   <= '0;
          if (tx_data_valid && tx_data_ready) begin
            data_latch    <= tx_data;
            state         <= S_START;
            tx_pin        <= 1'b0;
            tx_data_ready <= 1'b0;
          end else begin
            tx_pin        <= 1'b1;
            tx_data_ready <= 1'b1;
          end
        end
        S_START: begin
          if (bit_done) begin
            state     <= S_SEND_BYTE;
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            tx_pin    <= data_latch[0];
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        S_SEND_BYTE: begin
          if (bit_done) begin
            cycle_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                state  <= S_PARITY;
                tx_pin <= parity_bit;
              end else begin
                state  <= S_STOP;
                tx_pin <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_pin  <= data_latch[bit_cnt + 3'd1];
            end
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            state     <= S_STOP;
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            tx_pin    <= 1'b1;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        S_STOP: begin
          // bit_cnt counts stop bits here so cycle_cnt still fits one bit time.
          if (bit_done) begin
            cycle_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              state         <= S_IDLE;
              bit_cnt       <= '0;
              tx_data_ready <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        default: begin
          state         <= S_IDLE;
          tx_pin        <= 1'b1;
          tx_data_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CYCLE=10: frame shape, handshake timing,
// parity modes, two stop bits, late data changes and mid-frame reset.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data [3];
  logic       tx_data_valid [3];
  logic       ready0, ready1, ready2;
  logic       pin0, pin1, pin2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .PARITY(0), .STOP_BITS(1)) dut_plain (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_data_valid(tx_data_valid[0]),
    .tx_data_ready(ready0), .tx_pin(pin0)
  );

  uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .PARITY(2), .STOP_BITS(2)) dut_even (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_data_valid(tx_data_valid[1]),
    .tx_data_ready(ready1), .tx_pin(pin1)
  );

  uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .PARITY(1), .STOP_BITS(1)) dut_odd (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_data_valid(tx_data_valid[2]),
    .tx_data_ready(ready2), .tx_pin(pin2)
  );

  function automatic logic pinOf(input int idx);
    return (idx == 0) ? pin0 : (idx == 1) ? pin1 : pin2;
  endfunction

  function automatic logic readyOf(input int idx);
    return (idx == 0) ? ready0 : (idx == 1) ? ready1 : ready2;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitReady(input int idx);
    int n = 0;
    while (readyOf(idx) !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", int'(readyOf(idx)), 1);
  endtask

  // Returns at the negedge just after the accept edge (frame clock 0).
  task automatic applyStimulus(input int idx, input logic [7:0] data, input bit hold);
    waitReady(idx);
    tx_data[idx]       = data;
    tx_data_valid[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) tx_data_valid[idx] = 1'b0;
  endtask

  // Samples every clock of the frame and ends at the negedge F clocks after accept.
  task automatic checkFrame(input int idx, input logic [7:0] data, input int par_en,
                            input logic par_bit, input int stops, input bit meddle,
                            input string tag);
    int nbits = 10 + par_en + stops - 1;
    int f = nbits * 10;
    int match [12];
    int ready_hi = 0;
    int b;
    logic [7:0] rx = '0;
    logic exp_lvl;
    for (int i = 0; i < 12; i++) match[i] = 0;
    for (int k = 0; k < f; k++) begin
      b = k / 10;
      if (b == 0) exp_lvl = 1'b0;
      else if (b <= 8) exp_lvl = data[b-1];
      else if (b == 9 && par_en != 0) exp_lvl = par_bit;
      else exp_lvl = 1'b1;
      if (pinOf(idx) === exp_lvl) match[b]++;
      if (b >= 1 && b <= 8 && (k % 10) == 5) rx[b-1] = pinOf(idx);
      if (readyOf(idx) !== 1'b0) ready_hi++;
      if (meddle && k == 15) tx_data[idx] = 8'hFF;
      if (meddle && k == 30) tx_data_valid[idx] = 1'b1;
      if (meddle && k == 31) tx_data_valid[idx] = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < nbits; i++)
      checkOutput($sformatf("%s_bit%0d", tag, i), match[i], 10);
    checkOutput({tag, "_rx_byte"}, int'(rx), int'(data));
    checkOutput({tag, "_ready_low"}, ready_hi, 0);
    checkOutput({tag, "_ready_end"}, int'(readyOf(idx)), 1);
    checkOutput({tag, "_idle_pin"}, int'(pinOf(idx)), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lows;
    for (int i = 0; i < 3; i++) begin
      tx_data[i]       = 8'h00;
      tx_data_valid[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_pin0", int'(pin0), 1);
    checkOutput("reset_ready0", int'(ready0), 0);
    checkOutput("reset_pin1", int'(pin1), 1);
    checkOutput("reset_ready2", int'(ready2), 0);

    rst = 1'b0;
    checkOutput("release_ready", int'(ready0), 0);
    @(negedge clk);
    checkOutput("ready_after_1clk", int'(ready0), 1);
    checkOutput("idle_pin_after_release", int'(pin0), 1);

    $display("[TB] frame 0x55, no parity, 1 stop");
    applyStimulus(0, 8'h55, 1'b0);
    checkFrame(0, 8'h55, 0, 1'b0, 1, 1'b0, "p55");

    $display("[TB] back-to-back 0xA5, 0x3C");
    applyStimulus(0, 8'hA5, 1'b1);
    tx_data[0] = 8'h3C;
    checkFrame(0, 8'hA5, 0, 1'b0, 1, 1'b0, "bbA5");
    @(negedge clk);
    tx_data_valid[0] = 1'b0;
    checkFrame(0, 8'h3C, 0, 1'b0, 1, 1'b0, "bb3C");

    $display("[TB] 0x07 even parity, 2 stop bits; 0x07 odd parity");
    applyStimulus(1, 8'h07, 1'b0);
    checkFrame(1, 8'h07, 1, 1'b1, 2, 1'b0, "even07");
    applyStimulus(2, 8'h07, 1'b0);
    checkFrame(2, 8'h07, 1, 1'b0, 1, 1'b0, "odd07");

    $display("[TB] late data change and valid pulse while busy");
    applyStimulus(0, 8'h00, 1'b0);
    checkFrame(0, 8'h00, 0, 1'b0, 1, 1'b1, "late");
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      if (pin0 !== 1'b1) lows++;
      @(negedge clk);
    end
    checkOutput("no_extra_frame", lows, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'h00, 1'b0);
    repeat (35) @(negedge clk);
    checkOutput("pre_reset_pin", int'(pin0), 0);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_pin", int'(pin0), 1);
    checkOutput("async_reset_ready", int'(ready0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rerelease_ready", int'(ready0), 0);
    @(negedge clk);
    checkOutput("rerelease_ready_1clk", int'(ready0), 1);
    checkOutput("rerelease_pin", int'(pin0), 1);
    applyStimulus(0, 8'hC3, 1'b0);
    checkFrame(0, 8'hC3, 0, 1'b0, 1, 1'b0, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
